// File: rtl/ext_mem_arbiter.sv
// Two-port (instruction/data) cache-line arbiter onto a single external memory port.
// Fair round-robin between ports, one transaction at a time, with an ack timeout.
module ext_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 256,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              d_req,
    input  logic              i_we,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] i_data_i,
    input  logic [DATA_W-1:0] d_data_i,
    output logic [DATA_W-1:0] i_data_o,
    output logic [DATA_W-1:0] d_data_o,
    output logic              i_ack,
    output logic              d_ack,
    output logic              i_err,
    output logic              d_err,
    input  logic [DATA_W-1:0] ext_mem_data_i,
    input  logic              ext_mem_ack,
    output logic [DATA_W-1:0] ext_mem_data_o,
    output logic [ADDR_W-1:0] ext_mem_addr,
    output logic              ext_mem_cs,
    output logic              ext_mem_we
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last_d;
    logic                r_gnt_d;
    logic [7:0]          r_wait_cnt;
    logic                r_cs;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_i_data;
    logic [DATA_W-1:0]   r_d_data;
    logic                r_i_ack;
    logic                r_d_ack;
    logic                r_i_err;
    logic                r_d_err;

    logic                w_grant;
    logic                w_pick_d;
    logic                w_complete;
    logic                w_abort;

    // Data port wins only if it is alone or the instruction port was served last.
    assign w_pick_d = d_req && (!i_req || !r_last_d);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_complete  = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req || d_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (ext_mem_ack) begin
                    w_complete  = 1'b1;
                    w_state_nxt = DONE;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_abort     = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_d   <= 1'b1;
            r_gnt_d    <= 1'b0;
            r_wait_cnt <= 8'd0;
            r_cs       <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_i_data   <= '0;
            r_d_data   <= '0;
            r_i_ack    <= 1'b0;
            r_d_ack    <= 1'b0;
            r_i_err    <= 1'b0;
            r_d_err    <= 1'b0;
        end else begin
            if (w_grant) begin
                r_gnt_d    <= w_pick_d;
                r_last_d   <= w_pick_d;
                r_cs       <= 1'b1;
                r_we       <= w_pick_d ? d_we     : i_we;
                r_addr     <= w_pick_d ? d_addr   : i_addr;
                r_wdata    <= w_pick_d ? d_data_i : i_data_i;
                r_wait_cnt <= 8'd0;
            end

            if (r_state == BUSY && !ext_mem_ack) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end

            // Completion or abort: drop cs and stage the one-cycle ack for DONE.
            if (w_complete || w_abort) begin
                r_cs <= 1'b0;
                if (r_gnt_d) begin
                    r_d_ack <= 1'b1;
                    r_d_err <= w_abort;
                    if (w_abort) begin
                        r_d_data <= '0;
                    end else if (!r_we) begin
                        r_d_data <= ext_mem_data_i;
                    end
                end else begin
                    r_i_ack <= 1'b1;
                    r_i_err <= w_abort;
                    if (w_abort) begin
                        r_i_data <= '0;
                    end else if (!r_we) begin
                        r_i_data <= ext_mem_data_i;
                    end
                end
            end

            if (r_state == DONE) begin
                r_i_ack <= 1'b0;
                r_d_ack <= 1'b0;
                r_i_err <= 1'b0;
                r_d_err <= 1'b0;
            end
        end
    end

    assign ext_mem_cs     = r_cs;
    assign ext_mem_we     = r_we;
    assign ext_mem_addr   = r_addr;
    assign ext_mem_data_o = r_wdata;
    assign i_data_o       = r_i_data;
    assign d_data_o       = r_d_data;
    assign i_ack          = r_i_ack;
    assign d_ack          = r_d_ack;
    assign i_err          = r_i_err;
    assign d_err          = r_d_err;

endmodule

// File: doc/ext_mem_arbiter.md
EXT_MEM_ARBITER -- requirements
Module: ext_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, the address width of all ports.
REQ-002 The block SHALL have parameter DATA_W, default 256, the cache-line width of all data ports.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, the maximum number of cycles to wait for ext_mem_ack (range 1..255).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, the reset: asynchronous and active-low.
REQ-006 The block SHALL have ports i_req/d_req, input, 1 each, the line request from the instruction-side/data-side cache.
REQ-007 The block SHALL have ports i_we/d_we, input, 1 each: 1 = line write-back, 0 = line refill.
REQ-008 The block SHALL have ports i_addr/d_addr, input, ADDR_W each, the line address.
REQ-009 The block SHALL have ports i_data_i/d_data_i, input, DATA_W each, the write-back line.
REQ-010 The block SHALL have ports i_data_o/d_data_o, output, DATA_W each, the refill line.
REQ-011 The block SHALL have ports i_ack/d_ack, output, 1 each, a one-cycle completion pulse.
REQ-012 The block SHALL have ports i_err/d_err, output, 1 each, a one-cycle timeout pulse, coincident with the matching ack.
REQ-013 The block SHALL have port ext_mem_data_i, input, DATA_W, the read line from external memory.
REQ-014 The block SHALL have port ext_mem_ack, input, 1, completion from external memory.
REQ-015 The block SHALL have port ext_mem_data_o, output, DATA_W, the write line to external memory.
REQ-016 The block SHALL have port ext_mem_addr, output, ADDR_W, the address to external memory.
REQ-017 The block SHALL have ports ext_mem_cs and ext_mem_we, output, 1 each, the external memory chip select and write enable.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-019 In IDLE with any request pending, the block SHALL grant exactly one port, register that port's we/addr/data_i into the ext_mem_* outputs, and go to BUSY on the next edge.
REQ-020 When only one request is pending, that port SHALL win.
REQ-021 When both requests are pending, the port not granted most recently SHALL win; after reset the instruction port SHALL have priority.
REQ-022 The last-grant pointer SHALL update only on grant.
REQ-023 In BUSY, ext_mem_cs SHALL be 1, and ext_mem_we/addr/data_o SHALL hold constant.
REQ-024 Requester inputs SHALL be ignored after grant, including a req deasserted mid-transaction; the transaction still completes and acks.
REQ-025 In BUSY, ext_mem_ack=1 SHALL capture ext_mem_data_i into the granted port's data_o (reads only) and move to DONE, dropping ext_mem_cs on the same edge.
REQ-026 Each BUSY cycle without ext_mem_ack SHALL increment an 8-bit wait counter, cleared on grant.
REQ-027 When the counter reaches TIMEOUT, the block SHALL abort to DONE with ext_mem_cs dropped, the port's data_o = 0 and err set.
REQ-028 In DONE, the block SHALL assert the granted port's ack (and err if aborted) for exactly one cycle, then return to IDLE.
REQ-029 Requests SHALL NOT be sampled in DONE, so a requester holding req in the ack cycle is not re-granted for that stale request.
REQ-030 Latency SHALL be: req seen in IDLE at edge N -> ext_mem_cs=1 from N+1; ext_mem_ack sampled at edge M -> port ack high in cycle M+1. Minimum turnaround is 3 cycles.
REQ-031 ext_mem_ack in IDLE or DONE SHALL be ignored.
REQ-032 The ungranted port's ack, err and data_o SHALL hold their previous value.
REQ-033 Each data_o SHALL hold its value until that port's next refill completes.
REQ-034 ext_mem_cs SHALL never be 1 outside BUSY.
REQ-035 The two acks SHALL never be 1 in the same cycle.

Reset
REQ-036 When rst=0, the following SHALL apply immediately, without waiting for clk:
- state = IDLE
- last-grant pointer = data port, so the instruction port has priority
- wait counter = 0
- all outputs = 0
REQ-037 A reset asserted mid-BUSY SHALL abandon the transaction with no ack or err to either port.
REQ-038 After rst returns high, the first grant SHALL occur on the first rising edge with rst=1 and a req pending.

Verification
REQ-039 The bench SHALL cover a single read: i_req=1, i_we=0, i_addr=0x100; memory acks 4 cycles after cs -> ext_mem_addr=0x100, cs high 4 cycles, i_ack one pulse, i_data_o = memory line, d_ack stays 0.
REQ-040 The bench SHALL cover contention: i_req and d_req held high from reset for 4 transactions -> grant order I, D, I, D, with no cs gap longer than 2 cycles.
REQ-041 The bench SHALL cover a write: d_req=1, d_we=1, d_addr=0x2000, d_data_i=0xA5 repeated -> ext_mem_we=1, ext_mem_data_o=0xA5 pattern, d_ack pulses, d_data_o unchanged.
REQ-042 The bench SHALL cover timeout: TIMEOUT=8, memory never acks -> cs high exactly 8 cycles, then d_ack=d_err=1 for one cycle, d_data_o=0, FSM back to IDLE.
REQ-043 The bench SHALL cover reset mid-operation: rst=0 on cycle 2 of BUSY -> cs=0 immediately, no ack; after release with i_req=1 and d_req=1, the instruction port is granted first.
